uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Packet-granular round-robin arbiter that shares one `uart_tx` transmitter among `P_REQ_NUM` byte-stream requesters. It sits between user logic and the transmit side of `uart_drive`. Its output handshake drives `uart_tx`'s `i_user_tx_data`, `i_uart_tx_valid` and `o_user_tx_ready`. Once a requester is granted, it keeps the UART until its byte flagged `last` is accepted, so frames from different requesters never interleave on the line.

## Interface
Parameters:
- `P_REQ_NUM`, 4, number of requesters (2..16).
- `P_UART_DATAWIDTH`, 8, byte width; must match `uart_tx`.
- `P_IDLE_TIMEOUT`, 1024, stall cycles before a grant is revoked (used only with `UART_ARB_TIMEOUT_EN`); must be ≥2.

Ports:
- `i_clk`  in  1  system clock; the only clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req_data`  in  `P_REQ_NUM*P_UART_DATAWIDTH`  requester k's byte at `[k*P_UART_DATAWIDTH +: P_UART_DATAWIDTH]`.
- `i_req_valid`  in  `P_REQ_NUM`  per-requester byte valid.
- `i_req_last`  in  `P_REQ_NUM`  marks the final byte of a packet; qualified by valid.
- `o_req_ready`  out  `P_REQ_NUM`  per-requester accept.
- `o_uart_tx_data`  out  `P_UART_DATAWIDTH`  goes to `uart_tx` `i_user_tx_data`.
- `o_uart_tx_valid`  out  1  goes to `uart_tx` `i_uart_tx_valid`.
- `i_uart_tx_ready`  in  1  comes from `uart_tx` `o_user_tx_ready`.
- `o_grant`  out  `P_REQ_NUM`  one-hot current owner; all zero when idle.
- `o_busy`  out  1  high while a grant is held.
- `o_timeout`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM with two states, `S_IDLE` and `S_GRANT`. The grant register and the priority pointer `r_last` are both registered.
- **S_IDLE**
  - If `i_req_valid != 0`: pick the first valid requester searching upward, with wrap-around, from `r_last+1`.
  - Load `o_grant` with that one-hot value and move to `S_GRANT`.
  - With no valid requester, stay in `S_IDLE`.
  - All `o_req_ready` are 0 and `o_uart_tx_valid` is 0.
- **S_GRANT**, owner g:
  - Combinational pass-through: `o_uart_tx_data = data[g]`, `o_uart_tx_valid = i_req_valid[g]`, `o_req_ready[g] = i_uart_tx_ready`.
  - All other ready bits are 0.
- A transfer occurs when `o_uart_tx_valid && i_uart_tx_ready`.
- A transfer with `i_req_last[g]=1` does three things: set `r_last <= g`, clear `o_grant`, and go to `S_IDLE`.
- Requests arriving from non-owners while in `S_GRANT` are held off (ready=0) and are considered at the next `S_IDLE`.
- An owner that drops valid mid-packet keeps the grant (unless timeout is enabled).
- A single-byte packet (valid and last in the same byte) is legal.
- `o_busy = (state == S_GRANT)`.
- **Reset**:
  - State is `S_IDLE`.
  - `r_last = P_REQ_NUM-1`, so requester 0 wins first.
  - `o_grant = 0`, `o_busy = 0`, `o_timeout = 0`, `o_uart_tx_valid = 0`, `o_uart_tx_data = 0`, `o_req_ready = 0`.
- Reset asserted mid-packet drops the grant immediately. The partially sent packet is not resumed; upstream must re-send it.

## Timing
- A valid arriving in `S_IDLE` gives the grant on the next edge. The first byte can transfer in the cycle after that. Arbitration latency is 1 cycle.
- Between packets there is exactly one `S_IDLE` cycle, even when other requesters are waiting.
- Within a packet, throughput is set only by `i_uart_tx_ready`; the arbiter adds no cycles.
- `o_uart_tx_valid` and `o_req_ready` are combinational from registered grant plus inputs.
- `o_uart_tx_valid` does not depend on `i_uart_tx_ready`, so there is no loop.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,… per packet.

## Configuration
- **`UART_ARB_TIMEOUT_EN` defined**:
  - In `S_GRANT`, a counter increments on each cycle with `i_req_valid[g]=0` and clears on any cycle with `i_req_valid[g]=1`.
  - When the count reaches `P_IDLE_TIMEOUT-1` it does three things:
    - pulse `o_timeout` for 1 cycle;
    - set `r_last <= g`;
    - go to `S_IDLE`.
  - The counter is `$clog2(P_IDLE_TIMEOUT)` bits wide and is cleared on grant and on reset.
- **Undefined**: no counter; a grant is held until `last`; `o_timeout` is tied 0.

## Structure
- Shared package `uart_pkg`:
  - state encodings `S_IDLE`/`S_GRANT`;
  - a `clog2` helper;
  - the default byte width.
- Sub-module `uart_rr_pick`: combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner and a `found` flag.
  - Implemented by a doubled-vector priority search.

## Test plan
- **Reset / single packet**: after reset, requester 2 sends bytes 0x41,0x42,0x43 (last on 0x43) with ready always 1. Required: `o_grant=4'b0100` one cycle after valid; UART sees 41,42,43; then `o_grant=0`.
- **Round-robin**: all 4 requesters continuously send 2-byte packets. Required: grant order 0,1,2,3,0, with one idle cycle between packets.
- **No interleave**: requester 1 is mid-packet with ready toggling 1/0; requester 0 asserts valid. Required: `o_req_ready[0]` stays 0 until requester 1's last byte transfers.
- **Backpressure**: ready held low for 100 cycles with owner valid. Required: data stable, no transfer, grant held.
- **Timeout** (macro on, `P_IDLE_TIMEOUT=16`): owner drops valid mid-packet. Required: `o_timeout` pulses after 16 stalled cycles; next waiting requester is granted.
- **Mid-packet reset**: `i_rst` asserted during requester 3's packet. Required: all outputs 0 next cycle; requester 0 wins next arbitration.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit arbiter.
// Holds the arbiter state encoding, the default byte width, and a
// constant-function ceil(log2) used to size pointers and counters.
package uart_pkg;

    localparam int UART_DEFAULT_DATAWIDTH = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arb_state_t;

    // Smallest number of bits able to index 'value' distinct items.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and UART-side handshake bundle.
// The master modport is the arbiter's view; slave is the user/UART side.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int P_REQ_NUM        = 4,
    parameter int P_UART_DATAWIDTH = UART_DEFAULT_DATAWIDTH
);

    logic [P_REQ_NUM*P_UART_DATAWIDTH-1:0] i_req_data;
    logic [P_REQ_NUM-1:0]                  i_req_valid;
    logic [P_REQ_NUM-1:0]                  i_req_last;
    logic [P_REQ_NUM-1:0]                  o_req_ready;
    logic [P_UART_DATAWIDTH-1:0]           o_uart_tx_data;
    logic                                  o_uart_tx_valid;
    logic                                  i_uart_tx_ready;
    logic [P_REQ_NUM-1:0]                  o_grant;
    logic                                  o_busy;
    logic                                  o_timeout;

    modport master (
        input  i_req_data, i_req_valid, i_req_last, i_uart_tx_ready,
        output o_req_ready, o_uart_tx_data, o_uart_tx_valid,
               o_grant, o_busy, o_timeout
    );

    modport slave (
        output i_req_data, i_req_valid, i_req_last, i_uart_tx_ready,
        input  o_req_ready, o_uart_tx_data, o_uart_tx_valid,
               o_grant, o_busy, o_timeout
    );

endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
// Searches the request vector upward from last_ptr+1 with wrap-around by
// scanning a doubled copy of the vector, so no explicit modulo on the search.
module uart_rr_pick #(
    parameter int P_REQ_NUM = 4,
    parameter int P_PTR_W   = 2
) (
    input  logic [P_REQ_NUM-1:0] req_vec,
    input  logic [P_PTR_W-1:0]   last_ptr,
    output logic [P_REQ_NUM-1:0] winner,
    output logic                 found
);

    logic [2*P_REQ_NUM-1:0] dbl_req;

    assign dbl_req = {req_vec, req_vec};

    // First set bit at or after last_ptr+1 in the doubled vector wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < P_REQ_NUM; i++) begin
            if (!found && dbl_req[int'(last_ptr) + 1 + i]) begin
                found = 1'b1;
                winner[(int'(last_ptr) + 1 + i) % P_REQ_NUM] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one uart_tx.
// A granted requester owns the UART until its 'last' byte is accepted.
// Optional feature macro: UART_ARB_TIMEOUT_EN revokes a grant whose owner
// has stalled (valid low) for P_IDLE_TIMEOUT cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int P_REQ_NUM        = 4,
    parameter int P_UART_DATAWIDTH = UART_DEFAULT_DATAWIDTH,
    parameter int P_IDLE_TIMEOUT   = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    uart_tx_arbiter_if.master     bus
);

    localparam int PTR_W = clog2(P_REQ_NUM);

    arb_state_t                  state;
    logic [P_REQ_NUM-1:0]        grant_q;
    logic [PTR_W-1:0]            r_last;
    logic [P_REQ_NUM-1:0]        pick_grant;
    logic                        pick_found;
    logic [PTR_W-1:0]            owner_idx;
    logic [P_UART_DATAWIDTH-1:0] tx_data;
    logic                        tx_valid;
    logic                        owner_last;

    if (P_REQ_NUM < 2 || P_REQ_NUM > 16) begin : g_bad_req_num
        $error("uart_tx_arbiter: P_REQ_NUM must be in 2..16");
    end
    if (P_IDLE_TIMEOUT < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: P_IDLE_TIMEOUT must be >= 2");
    end

    uart_rr_pick #(
        .P_REQ_NUM (P_REQ_NUM),
        .P_PTR_W   (PTR_W)
    ) u_pick (
        .req_vec  (bus.i_req_valid),
        .last_ptr (r_last),
        .winner   (pick_grant),
        .found    (pick_found)
    );

    // Route the owner's byte stream straight through; zero when nobody owns.
    always_comb begin
        tx_data    = '0;
        tx_valid   = 1'b0;
        owner_last = 1'b0;
        owner_idx  = '0;
        for (int k = 0; k < P_REQ_NUM; k++) begin
            if (grant_q[k]) begin
                owner_idx  = PTR_W'(k);
                tx_data    = bus.i_req_data[k*P_UART_DATAWIDTH +: P_UART_DATAWIDTH];
                tx_valid   = bus.i_req_valid[k];
                owner_last = bus.i_req_last[k];
            end
        end
    end

    assign bus.o_uart_tx_data  = tx_data;
    assign bus.o_uart_tx_valid = tx_valid;
    assign bus.o_req_ready     = grant_q & {P_REQ_NUM{bus.i_uart_tx_ready}};
    assign bus.o_grant         = grant_q;
    assign bus.o_busy          = (state == S_GRANT);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(P_IDLE_TIMEOUT);

    logic [CNT_W-1:0] idle_cnt;
    logic             timeout_q;

    assign bus.o_timeout = timeout_q;
`else
    assign bus.o_timeout = 1'b0;
`endif

    // Arbiter FSM: grab a winner in IDLE, release on the owner's last byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            grant_q <= '0;
            r_last  <= PTR_W'(P_REQ_NUM - 1);
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_grant;
                        state   <= S_GRANT;
`ifdef UART_ARB_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                end
                S_GRANT: begin
                    if (tx_valid && bus.i_uart_tx_ready && owner_last) begin
                        r_last  <= owner_idx;
                        grant_q <= '0;
                        state   <= S_IDLE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (tx_valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == CNT_W'(P_IDLE_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        r_last    <= owner_idx;
                        grant_q   <= '0;
                        state     <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state   <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule
